ram_bist: RTL and testbench

- Built-in self-test initiator for the single-port synchronous `ram` block; drives the same `din`, `addr`, `ce`, `we` pins and samples `dout`.
- Runs a four-phase pattern test over the whole array: write p, read/verify p, write ~p, read/verify ~p. p = addr ^ seed.
- Reports pass/fail, a saturating error count and details of the first failure.
- Sits between the RAM and either a testcase or the system's power-on test logic.

---
 rtl/ram_bist_if.sv | 28 ++
 rtl/ram_bist.sv | 218 +++++++++++++++++++++
 tb/tb_ram_bist.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_if.sv
// Bus between the BIST initiator and the single-port synchronous RAM.
// The master drives din/addr/ce/we and samples dout one cycle after a read.
interface ram_bist_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] ram_din;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ce;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_din,
        output ram_addr,
        output ram_ce,
        output ram_we,
        input  ram_dout
    );

    modport slave (
        input  ram_din,
        input  ram_addr,
        input  ram_ce,
        input  ram_we,
        output ram_dout
    );
endinterface

// File: rtl/ram_bist.sv
// Four-phase RAM self-test: write p, verify p, write ~p, verify ~p, with p = addr ^ seed.
// Reports pass/fail, a saturating mismatch count and the first failing location.
module ram_bist #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int LAST_ADDR = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [DATA_W-1:0] seed_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [7:0]        err_count_o,
    output logic              fail_valid_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_exp_o,
    output logic [DATA_W-1:0] fail_got_o,
    ram_bist_if.master        ram
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR0  = 3'd1,
        S_RD0  = 3'd2,
        S_CHK0 = 3'd3,
        S_WR1  = 3'd4,
        S_RD1  = 3'd5,
        S_CHK1 = 3'd6,
        S_FIN  = 3'd7
    } state_e;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic              inv);
        logic [DATA_W-1:0] p;
        p = DATA_W'(a) ^ s;
        return inv ? ~p : p;
    endfunction

    state_e            state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              fail_valid_q, fail_valid_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_exp_q, rd_exp_d;
    logic              start_acc_s;
    logic              last_s;
    logic              mismatch_s;
    logic              next_wr_s;
    logic              next_acc_s;

    assign start_acc_s = (state_q == S_IDLE) && start_i;
    assign last_s      = (ram_addr_q == LAST_A);
    assign mismatch_s  = rd_vld_q && (ram.ram_dout != rd_exp_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each sweep phase ends only after LAST_ADDR has been issued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_WR0;  else state_d = S_IDLE;
            S_WR0:   if (last_s)  state_d = S_RD0;  else state_d = S_WR0;
            S_RD0:   if (last_s)  state_d = S_CHK0; else state_d = S_RD0;
            S_CHK0:  state_d = S_WR1;
            S_WR1:   if (last_s)  state_d = S_RD1;  else state_d = S_WR1;
            S_RD1:   if (last_s)  state_d = S_CHK1; else state_d = S_RD1;
            S_CHK1:  state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values, derived from the upcoming state
    always_comb begin
        next_wr_s  = (state_d == S_WR0) || (state_d == S_WR1);
        next_acc_s = next_wr_s || (state_d == S_RD0) || (state_d == S_RD1);
        seed_d     = start_acc_s ? seed_i : seed_q;

        // Address restarts at zero on every phase change and holds outside the sweeps
        if (next_acc_s) begin
            if (state_d == state_q) begin
                ram_addr_d = ram_addr_q + ADDR_W'(1);
            end else begin
                ram_addr_d = '0;
            end
        end else begin
            ram_addr_d = ram_addr_q;
        end

        ram_ce_d = next_acc_s;
        ram_we_d = next_wr_s;
        if (next_wr_s) begin
            ram_din_d = pattern(ram_addr_d, seed_d, state_d == S_WR1);
        end else begin
            ram_din_d = '0;
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d = (state_d == S_FIN);

        rd_vld_d  = ram_ce_q && !ram_we_q;
        rd_addr_d = ram_addr_q;
        rd_exp_d  = pattern(ram_addr_q, seed_q, state_q == S_RD1);

        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_addr_d  = fail_addr_q;
        fail_exp_d   = fail_exp_q;
        fail_got_d   = fail_got_q;
        if (start_acc_s) begin
            err_count_d  = 8'd0;
            fail_valid_d = 1'b0;
            fail_addr_d  = '0;
            fail_exp_d   = '0;
            fail_got_d   = '0;
        end else if (mismatch_s) begin
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end else begin
                err_count_d = err_count_q;
            end
            if (!fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_addr_d  = rd_addr_q;
                fail_exp_d   = rd_exp_q;
                fail_got_d   = ram.ram_dout;
            end else begin
                fail_valid_d = fail_valid_q;
            end
        end else begin
            err_count_d = err_count_q;
        end

        // The last compare lands on the CHK1 edge, so the verdict uses the updated count
        if (start_acc_s) begin
            pass_d = 1'b0;
        end else if (state_q == S_CHK1) begin
            pass_d = (err_count_d == 8'd0);
        end else begin
            pass_d = pass_q;
        end
    end

    // Registered outputs, compare pipeline and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q       <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= 8'd0;
            fail_valid_q <= 1'b0;
            fail_addr_q  <= '0;
            fail_exp_q   <= '0;
            fail_got_q   <= '0;
            rd_vld_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_exp_q     <= '0;
        end else begin
            seed_q       <= seed_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_ce_q     <= ram_ce_d;
            ram_we_q     <= ram_we_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_addr_q  <= fail_addr_d;
            fail_exp_q   <= fail_exp_d;
            fail_got_q   <= fail_got_d;
            rd_vld_q     <= rd_vld_d;
            rd_addr_q    <= rd_addr_d;
            rd_exp_q     <= rd_exp_d;
        end
    end

    assign ram.ram_din   = ram_din_q;
    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_ce    = ram_ce_q;
    assign ram.ram_we    = ram_we_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign err_count_o   = err_count_q;
    assign fail_valid_o  = fail_valid_q;
    assign fail_addr_o   = fail_addr_q;
    assign fail_exp_o    = fail_exp_q;
    assign fail_got_o    = fail_got_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with fault injection, write log and a
// result model computed directly from the test's pattern rules.
module tb_ram_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] seed;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count, fail_addr, fail_exp, fail_got;

    ram_bist_if #(.ADDR_W(8), .DATA_W(8)) rif ();

    ram_bist #(.ADDR_W(8), .DATA_W(8), .LAST_ADDR(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .seed_i       (seed),
        .busy_o       (busy),
        .done_o       (done),
        .pass_o       (pass),
        .err_count_o  (err_count),
        .fail_valid_o (fail_valid),
        .fail_addr_o  (fail_addr),
        .fail_exp_o   (fail_exp),
        .fail_got_o   (fail_got),
        .ram          (rif)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         mode     = 0;     // 0 good RAM, 1 dout stuck at 0, 2 RD0 addr 0x10 reads 0xFF
    logic       clr      = 1'b0;
    logic [7:0] mem [256];
    logic [7:0] dout_raw;
    bit         ovr_q    = 1'b0;
    int         edge_cnt = 0;
    int         write_idx = 0;
    int         read_idx  = 0;
    logic [7:0] wr_addr_log [1024];
    logic [7:0] wr_data_log [1024];
    int         busy_cycles = 0;
    int         done_cnt    = 0;
    int         done_edge   = 0;
    int         e0          = 0;

    assign rif.ram_dout = (mode == 1) ? 8'h00 : (ovr_q ? 8'hFF : dout_raw);

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (clr) begin
            write_idx <= 0;
            read_idx  <= 0;
            ovr_q     <= 1'b0;
        end else if (rif.ram_ce) begin
            if (rif.ram_we) begin
                mem[rif.ram_addr] <= rif.ram_din;
                if (write_idx < 1024) begin
                    wr_addr_log[write_idx] <= rif.ram_addr;
                    wr_data_log[write_idx] <= rif.ram_din;
                end
                write_idx <= write_idx + 1;
            end else begin
                dout_raw <= mem[rif.ram_addr];
                ovr_q    <= (mode == 2) && (read_idx == 16);
                read_idx <= read_idx + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            busy_cycles <= 0;
            done_cnt    <= 0;
        end else begin
            if (busy) busy_cycles <= busy_cycles + 1;
            if (done) begin
                done_cnt  <= done_cnt + 1;
                done_edge <= edge_cnt;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected outcome of a full test from the pattern rules and the fault mode
    task automatic ref_model(input logic [7:0] s, input int m, output int e, output logic fv,
                             output logic [7:0] fa, output logic [7:0] fe, output logic [7:0] fg);
        logic [7:0] ex, got;
        e = 0; fv = 1'b0; fa = 8'h00; fe = 8'h00; fg = 8'h00;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < 256; a++) begin
                ex = 8'(a) ^ s;
                if (ph == 1) ex = ~ex;
                if (m == 1) got = 8'h00;
                else if (m == 2 && ph == 0 && a == 16) got = 8'hFF;
                else got = ex;
                if (got != ex) begin
                    if (e < 255) e++;
                    if (!fv) begin fv = 1'b1; fa = 8'(a); fe = ex; fg = got; end
                end
            end
        end
    endtask

    task automatic clear_logs();
        @(negedge clk); clr = 1'b1;
        @(negedge clk);
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic run_test(input string name, input logic [7:0] s, input int m, input bit repulse);
        int         exp_err, bad;
        logic       exp_fv;
        logic [7:0] exp_fa, exp_fe, exp_fg, ed;
        mode = m;
        clear_logs();
        seed = s; start = 1'b1;
        @(posedge clk); #1 e0 = edge_cnt;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c < 1100; c++) begin
            @(negedge clk);
            start = repulse && (c == 700);
        end
        start = 1'b0;
        ref_model(s, m, exp_err, exp_fv, exp_fa, exp_fe, exp_fg);
        chk({name, ":done_pulses"}, done_cnt, 1);
        chk({name, ":done_edge"}, done_edge - e0, 1026);
        chk({name, ":busy_cycles"}, busy_cycles, 1026);
        chk({name, ":busy_after"}, busy, 1'b0);
        chk({name, ":pass"}, pass, (exp_err == 0) ? 1 : 0);
        chk({name, ":err_count"}, err_count, exp_err);
        chk({name, ":fail_valid"}, fail_valid, exp_fv);
        chk({name, ":fail_addr"}, fail_addr, exp_fa);
        chk({name, ":fail_exp"}, fail_exp, exp_fe);
        chk({name, ":fail_got"}, fail_got, exp_fg);
        chk({name, ":write_count"}, write_idx, 512);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            ed = 8'(i % 256) ^ s;
            if (i >= 256) ed = ~ed;
            if (wr_addr_log[i] !== 8'(i % 256) || wr_data_log[i] !== ed) bad++;
        end
        chk({name, ":write_pattern"}, bad, 0);
    endtask

    initial begin
        bit         found;
        logic [7:0] rs;
        rst_n = 1'b0; start = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst:busy", busy, 1'b0);
        chk("rst:done", done, 1'b0);
        chk("rst:pass", pass, 1'b0);
        chk("rst:err_count", err_count, 8'h00);
        chk("rst:fail_valid", fail_valid, 1'b0);
        chk("rst:ce", rif.ram_ce, 1'b0);
        chk("rst:we", rif.ram_we, 1'b0);
        chk("rst:addr", rif.ram_addr, 8'h00);
        chk("rst:din", rif.ram_din, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_test("good_s00", 8'h00, 0, 1'b0);
        chk("s00:wr0_37", wr_data_log[8'h37], 8'h37);
        chk("s00:wr1_37", wr_data_log[256 + 8'h37], 8'hC8);

        run_test("good_sA5", 8'hA5, 0, 1'b0);
        chk("sA5:wr0_00", wr_data_log[0], 8'hA5);
        chk("sA5:wr0_01", wr_data_log[1], 8'hA4);
        chk("sA5:wr1_00", wr_data_log[256], 8'h5A);

        run_test("single_fault", 8'h00, 2, 1'b0);
        chk("single:err_count", err_count, 8'h01);
        chk("single:fail_addr", fail_addr, 8'h10);
        chk("single:fail_got", fail_got, 8'hFF);

        run_test("stuck_zero", 8'h00, 1, 1'b0);
        chk("stuck:err_sat", err_count, 8'hFF);
        chk("stuck:fail_addr", fail_addr, 8'h01);

        rs = 8'($urandom_range(0, 255));
        run_test("random_seed", rs, 0, 1'b0);

        run_test("restart_in_wr1", 8'h5C, 0, 1'b1);

        // Abort in the middle of RD0 and confirm a clean restart afterwards
        mode = 0;
        clear_logs();
        seed = 8'h11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (rif.ram_ce && !rif.ram_we && rif.ram_addr == 8'h40) found = 1'b1;
        end
        chk("abort:reached_rd0_40", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort:ce", rif.ram_ce, 1'b0);
        chk("abort:we", rif.ram_we, 1'b0);
        chk("abort:busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort:no_done", done_cnt, 0);
        chk("abort:err_count", err_count, 8'h00);
        chk("abort:fail_valid", fail_valid, 1'b0);
        chk("abort:pass", pass, 1'b0);
        run_test("after_abort", 8'h3C, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
